// File: rtl/ex_mult_ctrl_pkg.sv
// Shared types and decode helpers for the execute-stage multiply sequencer.
package ex_mult_pkg;

    localparam int CHUNK_W_DEF = 8;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_MADD  = 3'b010,
        OP_MADDU = 3'b011,
        OP_MSUB  = 3'b100,
        OP_MSUBU = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_signed(mult_op_t op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_acc(mult_op_t op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub(mult_op_t op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/ex_mult_ctrl_if.sv
// Request/result bundle between the execute stage and the multiply sequencer.
interface ex_mult_ctrl_if;
    import ex_mult_pkg::*;

    logic        Start;
    mult_op_t    Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Z;
    logic        N;

    modport master (output Start, Op, A, B, Flush,
                    input  Busy, Done, Hi, Lo, Z, N);
    modport slave  (input  Start, Op, A, B, Flush,
                    output Busy, Done, Hi, Lo, Z, N);
endinterface

// File: rtl/ex_mult_chunk.sv
// One 32xCHUNK_W unsigned partial product, placed at bit k*CHUNK_W of a 64-bit word.
module ex_mult_chunk
    import ex_mult_pkg::*;
#(
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic [31:0]        i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic [3:0]         i_k,
    output logic [63:0]        o_p
);

    logic [31+CHUNK_W:0] w_pp;

    assign w_pp = {{CHUNK_W{1'b0}}, i_a} * {32'b0, i_b};
    assign o_p  = 64'(w_pp) << (i_k * CHUNK_W);

endmodule

// File: rtl/ex_mult_ctrl.sv
// Iterative multiply sequencer owning HI/LO; MADD/MSUB family enabled by EX_MULT_ACC_EN.
module ex_mult_ctrl
    import ex_mult_pkg::*;
#(
    parameter int CHUNK_W = CHUNK_W_DEF
) (
    input  logic          Clock,
    input  logic          Reset,
    ex_mult_ctrl_if.slave bus
);

    localparam int STEPS = 32 / CHUNK_W;

    state_t      r_state;
    logic [3:0]  r_step;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_neg;
    logic [63:0] r_acc;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_z;
    logic        r_n;

    logic [63:0] w_pp;
    logic [63:0] w_prod;
    logic [63:0] w_new;
    logic        w_mult_op;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

`ifdef EX_MULT_ACC_EN
    logic r_is_acc;
    logic r_is_sub;

    assign w_mult_op = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU) || is_acc(bus.Op);
    assign w_new     = !r_is_acc ? w_prod :
                       r_is_sub  ? {r_hi, r_lo} - w_prod : {r_hi, r_lo} + w_prod;
`else
    // Accumulating op codes are not recognised here, so they fall through as no-ops.
    assign w_mult_op = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU);
    assign w_new     = w_prod;
`endif

    assign w_a_neg = is_signed(bus.Op) && bus.A[31];
    assign w_b_neg = is_signed(bus.Op) && bus.B[31];
    assign w_a_mag = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag = w_b_neg ? -bus.B : bus.B;
    assign w_prod  = r_neg ? -r_acc : r_acc;

    // r_b shifts down each CALC step so its low chunk is always the one for r_step.
    ex_mult_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
        .i_a (r_a),
        .i_b (r_b[CHUNK_W-1:0]),
        .i_k (r_step),
        .o_p (w_pp)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
`ifdef EX_MULT_ACC_EN
            r_is_acc <= 1'b0;
            r_is_sub <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Start && !bus.Flush) begin
                        if (bus.Op == OP_MTHI) begin
                            r_hi   <= bus.A;
                            r_done <= 1'b1;
                        end else if (bus.Op == OP_MTLO) begin
                            r_lo   <= bus.A;
                            r_done <= 1'b1;
                        end else if (w_mult_op) begin
                            r_a     <= w_a_mag;
                            r_b     <= w_b_mag;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_acc   <= '0;
                            r_step  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= CALC;
`ifdef EX_MULT_ACC_EN
                            r_is_acc <= is_acc(bus.Op);
                            r_is_sub <= is_sub(bus.Op);
`endif
                        end
                    end
                end
                CALC: begin
                    if (bus.Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc  <= r_acc + w_pp;
                        r_b    <= r_b >> CHUNK_W;
                        r_step <= r_step + 4'd1;
                        if (r_step == 4'(STEPS - 1))
                            r_state <= FIX;
                    end
                end
                FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (!bus.Flush) begin
                        r_hi   <= w_new[63:32];
                        r_lo   <= w_new[31:0];
                        r_z    <= (w_new == 64'd0);
                        r_n    <= w_new[63];
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The pipeline stalls on Busy, so a Start here means the stall logic upstream is broken.
    a_no_start_while_busy: assert property (@(posedge Clock) disable iff (Reset)
        !(bus.Start && (r_state != IDLE)));

    assign bus.Busy = r_busy;
    assign bus.Done = r_done;
    assign bus.Hi   = r_hi;
    assign bus.Lo   = r_lo;
    assign bus.Z    = r_z;
    assign bus.N    = r_n;

endmodule

// File: tb/tb_ex_mult_ctrl.sv
// Scoreboard bench for ex_mult_ctrl; expectations follow EX_MULT_ACC_EN when it is defined.
module tb_ex_mult_ctrl;
    import ex_mult_pkg::*;

    localparam int STEPS = 32 / 8;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
        logic        n;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   txn;
    exp_t sb[$];
    exp_t m;

    ex_mult_ctrl_if bus ();

    ex_mult_ctrl dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.Done === 1'b1) begin
            checks++;
            txn++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h with no pending op", bus.Hi, bus.Lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.Hi, bus.Lo, bus.Z, bus.N} !== e) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h z=%b n=%b expected hi=%h lo=%h z=%b n=%b",
                             bus.Hi, bus.Lo, bus.Z, bus.N, e.hi, e.lo, e.z, e.n);
                end else begin
                    $display("txn %0d: hi=%h lo=%h z=%b n=%b ok", txn, bus.Hi, bus.Lo, bus.Z, bus.N);
                end
            end
        end
    end

    task automatic issue(input mult_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic run_mult(input mult_op_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi, input logic [31:0] lo);
        m.hi = hi;
        m.lo = lo;
        m.z  = (hi == 32'd0) && (lo == 32'd0);
        m.n  = hi[31];
        sb.push_back(m);
        issue(op, a, b);
        for (int i = 0; i < STEPS + 1; i++) begin
            @(negedge clk);
            chk("busy_high", {63'd0, bus.Busy}, 64'd1);
        end
        @(negedge clk);
        chk("busy_end", {63'd0, bus.Busy}, 64'd0);
        chk("done_latency", {63'd0, bus.Done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_mt(input mult_op_t op, input logic [31:0] a);
        if (op == OP_MTHI) m.hi = a;
        else               m.lo = a;
        sb.push_back(m);
        issue(op, a, 32'd0);
        @(negedge clk);
        chk("mt_busy", {63'd0, bus.Busy}, 64'd0);
        chk("mt_done", {63'd0, bus.Done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

`ifndef EX_MULT_ACC_EN
    task automatic run_noop(input mult_op_t op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        for (int i = 0; i < STEPS + 3; i++) begin
            @(negedge clk);
            chk("noop_busy", {63'd0, bus.Busy}, 64'd0);
            chk("noop_done", {63'd0, bus.Done}, 64'd0);
        end
        chk("noop_hilo", {bus.Hi, bus.Lo}, {m.hi, m.lo});
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        txn       = 0;
        m         = '0;
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.Op    = OP_MULT;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {63'd0, bus.Busy}, 64'd0);
        chk("reset_done", {63'd0, bus.Done}, 64'd0);
        chk("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
        chk("reset_zn",   {62'd0, bus.Z, bus.N}, 64'd0);
        @(posedge clk);
        #1;

        run_mult(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_mult(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_mult(OP_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9);
        run_mult(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        run_mt(OP_MTHI, 32'd0);
        run_mt(OP_MTLO, 32'd10);
`ifdef EX_MULT_ACC_EN
        run_mult(OP_MADD,  32'd3, 32'd4,        32'd0, 32'h00000016);
        run_mult(OP_MSUBU, 32'd2, 32'h0000000B, 32'd0, 32'h00000000);
        run_mult(OP_MSUB,  32'hFFFFFFFE, 32'd3, 32'd0, 32'h00000006);
`else
        run_noop(OP_MADD,  32'd3, 32'd4);
        run_noop(OP_MSUBU, 32'd2, 32'h0000000B);
`endif

        // Flush in cycle 3 of a MULT: Busy drops in cycle 4 and nothing commits.
        issue(OP_MULT, 32'd7, 32'd9);
        @(negedge clk);
        chk("flush_busy_c1", {63'd0, bus.Busy}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush_busy_c2", {63'd0, bus.Busy}, 64'd1);
        @(posedge clk);
        #1;
        bus.Flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_c3", {63'd0, bus.Busy}, 64'd1);
        @(posedge clk);
        #1;
        bus.Flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_c4", {63'd0, bus.Busy}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_done", {63'd0, bus.Done}, 64'd0);
        end
        chk("flush_hilo", {bus.Hi, bus.Lo}, {m.hi, m.lo});
        @(posedge clk);
        #1;
        run_mult(OP_MULT, 32'd2, 32'd2, 32'd0, 32'd4);

        // Reset in the middle of CALC clears HI/LO and kills the operation.
        issue(OP_MULTU, 32'd100, 32'd100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m   = '0;
        @(negedge clk);
        chk("rst_mid_busy", {63'd0, bus.Busy}, 64'd0);
        chk("rst_mid_hilo", {bus.Hi, bus.Lo}, 64'd0);
        chk("rst_mid_zn",   {62'd0, bus.Z, bus.N}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", {63'd0, bus.Done}, 64'd0);
        end
        @(posedge clk);
        #1;
        run_mult(OP_MULTU, 32'd100, 32'd100, 32'd0, 32'h00002710);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mult_ctrl.md
Name: ex_mult_ctrl

Overview:
- Multi-cycle multiply sequencer for the execute stage; owns the architectural HI/LO registers.
- Computes 32x32 products iteratively with a narrow 32xCHUNK_W partial-product multiplier instead of one wide combinational multiply.
- Supports signed/unsigned multiply, multiply-accumulate/subtract, and direct HI/LO writes.
- Raises Busy so the pipeline stalls while an operation is in flight.

Parameters:
- CHUNK_W, 8: bits of B consumed per CALC cycle. Legal values: 4, 8, 16, 32.
- STEPS, 32/CHUNK_W: number of CALC cycles. Derived value; must not be overridden.

Ports:
- Clock  in  1  : system clock, rising edge.
- Reset  in  1  : synchronous, active-high reset.
- Start  in  1  : request; sampled only in IDLE.
- Op  in  3  : operation code (mult_op_t).
- A  in  32  : multiplicand, or MTHI/MTLO source.
- B  in  32  : multiplier.
- Flush  in  1  : abort the in-flight operation.
- Busy  out  1  : high whenever state is not IDLE.
- Done  out  1  : one-cycle pulse on the cycle after HI/LO commit.
- Hi  out  32  : HI register.
- Lo  out  32  : LO register.
- Z  out  1  : high when {Hi,Lo}==0; updated on commit.
- N  out  1  : Hi[31]; updated on commit.

Behaviour:
- Interface: one clock (Clock); reset is synchronous and active-high (Reset).
- Reset: state=IDLE; Hi, Lo, Busy, Done, Z, N all 0; accumulator cleared.
- Op encoding: 000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU, 110 MTHI, 111 MTLO.
- IDLE + Start + MTHI/MTLO:
  - Hi (or Lo) <= A at the same edge.
  - Z/N unchanged; Done pulses next cycle; Busy stays 0.
- IDLE + Start + multiply op:
  - Latch |A|, |B|, result sign and op. Signed ops take magnitudes; unsigned ops take raw values.
  - Clear the accumulator and go to CALC. Step counter = 0.
- CALC:
  - acc += (|A| * B_chunk[k]) << (k*CHUNK_W), with k = step counter.
  - Stay STEPS cycles, then go to FIX.
  - Accumulator is 64 bits; no overflow is possible.
- FIX (1 cycle):
  - Negate the product if the sign bit is set.
  - MADD*: {Hi,Lo} <= {Hi,Lo} + p. MSUB*: {Hi,Lo} <= {Hi,Lo} - p. Both wrap modulo 2^64.
  - MULT*: {Hi,Lo} <= p.
  - Update Z/N, then go to IDLE. Done=1 on the next cycle.
- Latency: Start accepted at cycle 0 → Busy high cycles 1..STEPS+1 → HI/LO visible and Done=1 at cycle STEPS+2. For CHUNK_W=8 that is cycle 6.
- Start while Busy: ignored. The pipeline is stalled by Busy, so this must not occur; assert in simulation.
- Flush in CALC/FIX: go to IDLE next cycle. HI/LO/Z/N unchanged, no Done. Flush in IDLE is ignored.
- Flush coincident with Start in IDLE: Start is dropped.
- Reset mid-operation: treated as reset; HI/LO return to 0.

Optional Feature:
- Macro: EX_MULT_ACC_EN.
- Defined: MADD/MADDU/MSUB/MSUBU behave as above.
- Undefined:
  - Op codes 010-101 are no-ops: no state change, Busy stays 0, no Done.
  - The add/subtract path is not synthesised.

Decomposition:
- Package ex_mult_pkg:
  - typedef enum logic [2:0] mult_op_t
  - typedef enum state_t {IDLE, CALC, FIX}
  - default CHUNK_W localparam
  - function is_signed(op)
  - function is_acc(op)
- Sub-module ex_mult_chunk:
  - Combinational 32xCHUNK_W unsigned multiply plus left shift by k*CHUNK_W.
  - Output 64 bits.
  - Instantiated once.

Test Plan:
- Reset, then MULT A=-3 (FFFFFFFD), B=5 → Busy 5 cycles; Done at cycle 6; Hi=FFFFFFFF, Lo=FFFFFFF1, N=1, Z=0.
- MULTU A=FFFFFFFF, B=FFFFFFFF → Hi=FFFFFFFE, Lo=00000001.
- MTHI A=0, MTLO A=10, then MADD 3*4 → Lo=00000016, Hi=0. MSUBU 2*0x0B from there → Hi=0, Lo=0, Z=1.
- MULT 7*9, Flush asserted in cycle 3 → Busy falls at cycle 4; no Done; Hi/Lo keep prior values. Next MULT 2*2 → Lo=4.
- Reset asserted mid-CALC of MULTU 100*100 → next cycle Busy=0, Hi=Lo=0, no Done.
- EX_MULT_ACC_EN undefined: Start with MADD → Busy stays 0, no Done, Hi/Lo unchanged.
